// File: rtl/vx_barrier_unit.sv
// Per-core warp barrier table: local counting barriers plus global barriers negotiated with the socket.
// All outputs are registered; arrivals are always accepted, and requests to the socket are held until ready.
module vx_barrier_unit #(
   parameter int NUM_WARPS     = 8,
   parameter int NUM_BARRIERS  = 8,
   parameter int SIZE_BITS     = 3,
   parameter int GBAR_ENABLE   = 1,
   parameter int PERF_CTR_BITS = 44,
   localparam int NW_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
   localparam int NB_W = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req_valid,
   input  logic [NW_W-1:0]          req_wid,
   input  logic [NB_W-1:0]          req_id,
   input  logic                     req_is_global,
   input  logic [SIZE_BITS-1:0]     req_size_m1,
   input  logic                     req_is_noop,
   input  logic [NUM_WARPS-1:0]     active_wmask,
   output logic [NUM_WARPS-1:0]     stall_mask,
   output logic                     release_valid,
   output logic [NUM_WARPS-1:0]     release_mask,
   output logic                     gbar_req_valid,
   output logic [NB_W-1:0]          gbar_req_id,
   output logic [SIZE_BITS-1:0]     gbar_req_size_m1,
   input  logic                     gbar_req_ready,
   input  logic                     gbar_rsp_valid,
   input  logic [NB_W-1:0]          gbar_rsp_id,
   output logic [PERF_CTR_BITS-1:0] perf_stalls
);

   typedef enum logic [1:0] {S_IDLE, S_COUNT, S_GREQ, S_GWAIT} bar_state_t;

   bar_state_t           state_q [NUM_BARRIERS];
   bar_state_t           state_d [NUM_BARRIERS];
   logic [NUM_WARPS-1:0] mask_q  [NUM_BARRIERS];
   logic [NUM_WARPS-1:0] mask_d  [NUM_BARRIERS];
   logic [SIZE_BITS-1:0] cnt_q   [NUM_BARRIERS];
   logic [SIZE_BITS-1:0] cnt_d   [NUM_BARRIERS];
   logic [SIZE_BITS-1:0] size_q  [NUM_BARRIERS];
   logic [SIZE_BITS-1:0] size_d  [NUM_BARRIERS];
   logic                 glob_q  [NUM_BARRIERS];
   logic                 glob_d  [NUM_BARRIERS];

   logic [NUM_WARPS-1:0] wbit, rel_d, stall_set, stall_d;
   logic                 rel_v_d, fresh, eff_glob, noop, illegal;
   logic [SIZE_BITS-1:0] eff_size;
   logic                 greq_v_d;
   logic [NB_W-1:0]      greq_id_d;
   logic [SIZE_BITS-1:0] greq_size_d;

   always_comb begin
      state_d     = state_q;
      mask_d      = mask_q;
      cnt_d       = cnt_q;
      size_d      = size_q;
      glob_d      = glob_q;
      rel_d       = '0;
      rel_v_d     = 1'b0;
      stall_set   = '0;
      wbit        = '0;
      wbit[req_wid] = 1'b1;

      // The first arrival latches size and kind; later arrivals follow the latched values.
      fresh    = (state_q[req_id] == S_IDLE);
      eff_glob = fresh ? (req_is_global && (GBAR_ENABLE != 0)) : glob_q[req_id];
      eff_size = fresh ? req_size_m1 : size_q[req_id];
      noop     = req_is_noop || (!eff_glob && (eff_size == '0));
      illegal  = ((stall_mask & wbit) != '0) || (state_q[req_id] inside {S_GREQ, S_GWAIT});

      if (req_valid && !illegal && !noop) begin
         if (!eff_glob && (cnt_q[req_id] == eff_size)) begin
            rel_d          = rel_d | mask_q[req_id] | wbit;
            rel_v_d        = 1'b1;
            state_d[req_id] = S_IDLE;
            mask_d[req_id]  = '0;
            cnt_d[req_id]   = '0;
         end else begin
            mask_d[req_id]  = mask_q[req_id] | wbit;
            cnt_d[req_id]   = cnt_q[req_id] + 1'b1;
            size_d[req_id]  = eff_size;
            glob_d[req_id]  = eff_glob;
            stall_set       = wbit;
            state_d[req_id] = (eff_glob && ((mask_q[req_id] | wbit) == active_wmask)) ? S_GREQ : S_COUNT;
         end
      end

      // Only entries already waiting take a response, so a response racing the handshake is dropped.
      if (gbar_rsp_valid && (state_q[gbar_rsp_id] == S_GWAIT)) begin
         rel_d                = rel_d | mask_q[gbar_rsp_id];
         rel_v_d              = 1'b1;
         state_d[gbar_rsp_id] = S_IDLE;
         mask_d[gbar_rsp_id]  = '0;
         cnt_d[gbar_rsp_id]   = '0;
      end

      if (gbar_req_valid && gbar_req_ready)
         state_d[gbar_req_id] = S_GWAIT;

      greq_v_d    = gbar_req_valid;
      greq_id_d   = gbar_req_id;
      greq_size_d = gbar_req_size_m1;
      if (!(gbar_req_valid && !gbar_req_ready)) begin
         greq_v_d    = 1'b0;
         greq_id_d   = '0;
         greq_size_d = '0;
         for (int i = NUM_BARRIERS - 1; i >= 0; i--) begin
            if (state_d[i] == S_GREQ) begin
               greq_v_d    = 1'b1;
               greq_id_d   = NB_W'(i);
               greq_size_d = size_d[i];
            end
         end
      end

      stall_d = (stall_mask | stall_set) & ~rel_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_BARRIERS; i++) begin
            state_q[i] <= S_IDLE;
            mask_q[i]  <= '0;
            cnt_q[i]   <= '0;
            size_q[i]  <= '0;
            glob_q[i]  <= 1'b0;
         end
         stall_mask       <= '0;
         release_valid    <= 1'b0;
         release_mask     <= '0;
         gbar_req_valid   <= 1'b0;
         gbar_req_id      <= '0;
         gbar_req_size_m1 <= '0;
         perf_stalls      <= '0;
      end else begin
         state_q          <= state_d;
         mask_q           <= mask_d;
         cnt_q            <= cnt_d;
         size_q           <= size_d;
         glob_q           <= glob_d;
         stall_mask       <= stall_d;
         release_valid    <= rel_v_d;
         release_mask     <= rel_d;
         gbar_req_valid   <= greq_v_d;
         gbar_req_id      <= greq_id_d;
         gbar_req_size_m1 <= greq_size_d;
         perf_stalls      <= perf_stalls + PERF_CTR_BITS'(stall_mask != '0);
      end
   end

   a_legal_arrival: assert property (@(posedge clk) disable iff (reset) req_valid |-> !illegal);

endmodule

// File: tb/tb_vx_barrier_unit.sv
// Bench for vx_barrier_unit: directed scenarios plus randomized traffic against a set-based reference model.
module tb_vx_barrier_unit;
   localparam int NWARP = 8;
   localparam int NBAR  = 8;
   localparam int SB    = 3;
   localparam int PB    = 44;

   logic           clk = 1'b0;
   logic           reset;
   logic           req_valid, req_is_global, req_is_noop;
   logic [2:0]     req_wid, req_id;
   logic [SB-1:0]  req_size_m1;
   logic [NWARP-1:0] active_wmask;
   logic [NWARP-1:0] stall_mask, release_mask;
   logic           release_valid, gbar_req_valid, gbar_req_ready, gbar_rsp_valid;
   logic [2:0]     gbar_req_id, gbar_rsp_id;
   logic [SB-1:0]  gbar_req_size_m1;
   logic [PB-1:0]  perf_stalls;

   always #5 clk = ~clk;

   vx_barrier_unit #(.NUM_WARPS(NWARP), .NUM_BARRIERS(NBAR), .SIZE_BITS(SB),
                     .GBAR_ENABLE(1), .PERF_CTR_BITS(PB)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_wid(req_wid), .req_id(req_id),
      .req_is_global(req_is_global), .req_size_m1(req_size_m1), .req_is_noop(req_is_noop),
      .active_wmask(active_wmask), .stall_mask(stall_mask),
      .release_valid(release_valid), .release_mask(release_mask),
      .gbar_req_valid(gbar_req_valid), .gbar_req_id(gbar_req_id),
      .gbar_req_size_m1(gbar_req_size_m1), .gbar_req_ready(gbar_req_ready),
      .gbar_rsp_valid(gbar_rsp_valid), .gbar_rsp_id(gbar_rsp_id),
      .perf_stalls(perf_stalls)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference model: each barrier is a set of arrived warps plus a phase (0 collecting, 1 wants socket, 2 waits socket).
   bit [7:0]    m_arr  [NBAR];
   int          m_ph   [NBAR];
   int          m_size [NBAR];
   bit          m_glob [NBAR];
   bit [7:0]    e_stall, e_rel;
   bit          e_relv, e_reqv;
   int          e_reqid, e_reqsz;
   logic [PB-1:0] e_perf;

   task automatic model_reset();
      for (int i = 0; i < NBAR; i++) begin
         m_arr[i] = 0; m_ph[i] = 0; m_size[i] = 0; m_glob[i] = 0;
      end
      e_stall = 0; e_rel = 0; e_relv = 0; e_reqv = 0; e_reqid = 0; e_reqsz = 0; e_perf = 0;
   endtask

   task automatic model_step();
      bit [7:0] rel, add, w;
      bit fresh, g, nop;
      int s, id;
      rel = 0; add = 0;
      if (e_stall != 0) e_perf = e_perf + 1;
      if (req_valid) begin
         id = int'(req_id);
         w  = 8'(1) << req_wid;
         if ((e_stall & w) == 0 && m_ph[id] == 0) begin
            fresh = (m_arr[id] == 0);
            g     = fresh ? req_is_global : m_glob[id];
            s     = fresh ? int'(req_size_m1) : m_size[id];
            nop   = req_is_noop || (!g && s == 0);
            if (!nop) begin
               if (fresh) begin m_glob[id] = g; m_size[id] = s; end
               if (!g && $countones(m_arr[id]) == s) begin
                  rel |= m_arr[id] | w;
                  m_arr[id] = 0;
               end else begin
                  m_arr[id] |= w;
                  add |= w;
                  if (g && m_arr[id] == active_wmask) m_ph[id] = 1;
               end
            end
         end
      end
      if (gbar_rsp_valid && m_ph[gbar_rsp_id] == 2) begin
         rel |= m_arr[gbar_rsp_id];
         m_arr[gbar_rsp_id] = 0;
         m_ph[gbar_rsp_id] = 0;
      end
      if (e_reqv && gbar_req_ready) m_ph[e_reqid] = 2;
      e_stall = (e_stall | add) & ~rel;
      e_rel   = rel;
      e_relv  = (rel != 0);
      if (!(e_reqv && !gbar_req_ready)) begin
         e_reqv = 0; e_reqid = 0; e_reqsz = 0;
         for (int i = NBAR - 1; i >= 0; i--)
            if (m_ph[i] == 1) begin e_reqv = 1; e_reqid = i; e_reqsz = m_size[i]; end
      end
   endtask

   task automatic compare_all();
      chk("stall_mask", stall_mask, e_stall);
      chk("release_valid", release_valid, e_relv);
      chk("release_mask", release_mask, e_rel);
      chk("gbar_req_valid", gbar_req_valid, e_reqv);
      if (e_reqv) begin
         chk("gbar_req_id", gbar_req_id, e_reqid);
         chk("gbar_req_size", gbar_req_size_m1, e_reqsz);
      end
      chk("perf_stalls", perf_stalls, e_perf);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic idle_inputs();
      req_valid = 0; req_wid = 0; req_id = 0; req_is_global = 0; req_size_m1 = 0; req_is_noop = 0;
      gbar_req_ready = 0; gbar_rsp_valid = 0; gbar_rsp_id = 0;
   endtask

   task automatic arrive(input int w, input int id, input bit g, input int sz, input bit nop);
      req_valid = 1; req_wid = 3'(w); req_id = 3'(id); req_is_global = g;
      req_size_m1 = SB'(sz); req_is_noop = nop;
      tick();
      req_valid = 0; req_is_noop = 0;
   endtask

   task automatic do_reset();
      #2 reset = 1;
      model_reset();
      #1;
      compare_all();
      reset = 0;
      idle_inputs();
      tick();
   endtask

   initial begin
      int gid;
      bit [7:0] amask;
      bit [7:0] masks [5];
      idle_inputs();
      active_wmask = 8'h0F;
      reset = 1;
      model_reset();
      #12;
      compare_all();
      chk("reset_stall", stall_mask, 0);
      reset = 0;
      tick();

      // local barrier of four warps on id 2
      arrive(0, 2, 0, 3, 0); chk("loc_stall1", stall_mask, 8'h01);
      arrive(1, 2, 0, 3, 0); chk("loc_stall2", stall_mask, 8'h03);
      arrive(2, 2, 0, 3, 0); chk("loc_stall3", stall_mask, 8'h07);
      arrive(3, 2, 0, 3, 0);
      chk("loc_relv", release_valid, 1); chk("loc_relm", release_mask, 8'h0F);
      chk("loc_stall_clr", stall_mask, 0);
      tick(); chk("loc_pulse", release_valid, 0);

      // no-op arrivals, then a fresh barrier on the same id
      arrive(5, 0, 0, 2, 1); chk("noop_stall", stall_mask, 0);
      arrive(5, 0, 0, 0, 0); chk("sz0_stall", stall_mask, 0); chk("sz0_rel", release_valid, 0);
      arrive(5, 0, 0, 1, 0);
      arrive(6, 0, 0, 3, 0); chk("after_noop_rel", release_mask, 8'h60);

      // global barrier with held-off socket
      active_wmask = 8'h0F;
      for (int w = 0; w < 4; w++) arrive(w, 1, 1, 1, 0);
      chk("g_reqv", gbar_req_valid, 1); chk("g_reqid", gbar_req_id, 1);
      for (int k = 0; k < 3; k++) begin
         tick(); chk("g_hold_id", gbar_req_id, 1); chk("g_hold_sz", gbar_req_size_m1, 1);
      end
      gbar_req_ready = 1; tick(); gbar_req_ready = 0;
      chk("g_req_drop", gbar_req_valid, 0);
      gbar_rsp_valid = 1; gbar_rsp_id = 1; tick(); gbar_rsp_valid = 0;
      chk("g_relm", release_mask, 8'h0F); chk("g_stall_clr", stall_mask, 0);

      // fixed priority among pending global requests
      active_wmask = 8'h01; arrive(0, 2, 1, 1, 0);
      active_wmask = 8'h02; arrive(1, 6, 1, 1, 0);
      active_wmask = 8'h04; arrive(2, 4, 1, 1, 0);
      chk("pri_first", gbar_req_id, 2);
      gbar_req_ready = 1;
      tick(); chk("pri_second", gbar_req_id, 4);
      tick(); chk("pri_third", gbar_req_id, 6);
      tick(); chk("pri_empty", gbar_req_valid, 0);
      gbar_req_ready = 0;
      gbar_rsp_valid = 1; gbar_rsp_id = 7; tick(); chk("rsp_idle_ign", release_valid, 0);
      gbar_rsp_id = 2; tick();
      gbar_rsp_id = 4; tick();
      gbar_rsp_id = 6; tick(); chk("pri_rel6", release_mask, 8'h02);
      gbar_rsp_valid = 0; tick();

      // local completion and global response merged into one pulse
      active_wmask = 8'hF0;
      for (int w = 4; w < 8; w++) arrive(w, 3, 1, 1, 0);
      gbar_req_ready = 1; tick(); gbar_req_ready = 0;
      arrive(0, 0, 0, 1, 0);
      gbar_rsp_valid = 1; gbar_rsp_id = 3;
      arrive(1, 0, 0, 1, 0);
      gbar_rsp_valid = 0;
      chk("merge_relv", release_valid, 1); chk("merge_relm", release_mask, 8'hF3);
      tick();

      // reset while warps are stalled
      for (int w = 0; w < 3; w++) arrive(w, 5, 0, 7, 0);
      chk("pre_rst_stall", stall_mask, 8'h07);
      do_reset();
      chk("rst_stall", stall_mask, 0); chk("rst_rel", release_valid, 0); chk("rst_perf", perf_stalls, 0);
      arrive(3, 5, 0, 1, 0);
      arrive(4, 5, 0, 1, 0); chk("post_rst_rel", release_mask, 8'h18);

      // randomized traffic in epochs separated by resets
      masks[0] = 8'h03; masks[1] = 8'h0C; masks[2] = 8'h30; masks[3] = 8'hC0; masks[4] = 8'h0F;
      amask = 8'h03; gid = 0;
      for (int c = 0; c < 3000; c++) begin
         int w, id, start;
         bit g;
         if (c % 200 == 0) begin
            do_reset();
            amask = masks[$urandom_range(4, 0)];
            gid = $urandom_range(NBAR - 1, 0);
         end
         active_wmask = amask;
         w  = $urandom_range(NWARP - 1, 0);
         g  = ($urandom_range(2, 0) == 0);
         id = g ? gid : $urandom_range(NBAR - 1, 0);
         req_wid = 3'(w); req_id = 3'(id); req_is_global = g;
         req_size_m1 = SB'($urandom_range(3, 0));
         req_is_noop = ($urandom_range(7, 0) == 0);
         req_valid = ($urandom_range(1, 0) == 1) && !e_stall[w] && m_ph[id] == 0 && (!g || amask[w]);
         gbar_req_ready = ($urandom_range(1, 0) == 1);
         gbar_rsp_valid = ($urandom_range(3, 0) == 0);
         gbar_rsp_id = 3'($urandom_range(NBAR - 1, 0));
         start = $urandom_range(NBAR - 1, 0);
         for (int k = 0; k < NBAR; k++)
            if (m_ph[(start + k) % NBAR] == 2 && $urandom_range(1, 0) == 1)
               gbar_rsp_id = 3'((start + k) % NBAR);
         tick();
      end
      idle_inputs();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
